// File: rtl/pass_swap_stage_pkg.sv
// Shared definitions for the odd-even transposition sort stage.
//   - Default geometry (element count and width).
//   - Helpers that decide, at elaboration time, how elements are paired
//     for a given pass parity.
package pass_swap_stage_pkg;

  localparam int unsigned DefDim   = 8;
  localparam int unsigned DefWidth = 8;

  // Only the parity of the pass index matters: even passes pair (0,1),(2,3)..;
  // odd passes pair (1,2),(3,4)..
  function automatic int unsigned pair_base(input int unsigned pass);
    return pass % 2;
  endfunction

  // True when idx is the lower element of a compared pair.
  function automatic bit is_pair_lo(input int idx, input int base, input int dim);
    return (idx >= base) && (((idx - base) % 2) == 0) && (idx + 1 <= dim - 1);
  endfunction

  // True when idx is the upper element of a compared pair.
  function automatic bit is_pair_hi(input int idx, input int base, input int dim);
    return (idx >= 1) && is_pair_lo(idx - 1, base, dim);
  endfunction

endpackage

// File: rtl/pass_swap_stage_compare_swap.sv
// Compare-swap cell: combinational min/max of two unsigned values.
// Ports:
//   a, b  in   WIDTH  operands (a from the lower array index)
//   lo    out  WIDTH  min(a, b)
//   hi    out  WIDTH  max(a, b)
// On a tie nothing is swapped, which keeps the sort stable.
module pass_swap_stage_compare_swap
  import pass_swap_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic w_swap;

  always_comb begin
    // Strict compare: equal values stay in place.
    w_swap = (a > b);
    lo     = w_swap ? b : a;
    hi     = w_swap ? a : b;
  end

endmodule

// File: rtl/pass_swap_stage.sv
// One registered pass of an odd-even transposition sort.
// Adjacent pairs selected by PASS parity are compare-swapped so the lower
// index receives the smaller value; unpaired elements pass straight through.
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          pak_less carries a valid array
//   pak_less   in   DIM*WIDTH  input array, element j at [WIDTH*j +: WIDTH]
//   out_valid  out  1          pak_more carries the result of a valid input
//   pak_more   out  DIM*WIDTH  output array, same packing
module pass_swap_stage
  import pass_swap_stage_pkg::*;
#(
  parameter int unsigned DIM   = DefDim,
  parameter int unsigned PASS  = 0,
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DIM*WIDTH-1:0] pak_less,
  output logic                 out_valid,
  output logic [DIM*WIDTH-1:0] pak_more
);

  localparam int Base = int'(pair_base(PASS));
  localparam int Dim  = int'(DIM);

  logic [DIM*WIDTH-1:0] w_next;
  logic [DIM*WIDTH-1:0] r_data;
  logic                 r_valid;

  for (genvar j = 0; j < Dim; j++) begin : g_elem
    if (is_pair_lo(j, Base, Dim)) begin : g_pair
      // This cell also drives element j+1, so the upper index needs no wiring.
      pass_swap_stage_compare_swap #(
        .WIDTH (WIDTH)
      ) u_cmp (
        .a  (pak_less[j*WIDTH +: WIDTH]),
        .b  (pak_less[(j+1)*WIDTH +: WIDTH]),
        .lo (w_next[j*WIDTH +: WIDTH]),
        .hi (w_next[(j+1)*WIDTH +: WIDTH])
      );
    end else if (!is_pair_hi(j, Base, Dim)) begin : g_thru
      assign w_next[j*WIDTH +: WIDTH] = pak_less[j*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= in_valid;
      // Data holds when idle so downstream sees a stable bus.
      if (in_valid) begin
        r_data <= w_next;
      end
    end
  end

  assign out_valid = r_valid;
  assign pak_more  = r_data;

endmodule

// File: tb/tb_pass_swap_stage.sv
module tb_pass_swap_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] pak8;
  logic [39:0] pak5;

  logic        v_p0, v_p1, v_d5a, v_d5b;
  logic [63:0] d_p0, d_p1;
  logic [39:0] d_d5a, d_d5b;

  logic        c_v [0:8];
  logic [63:0] c_d [0:8];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  pass_swap_stage #(.DIM(8), .PASS(0), .WIDTH(8)) u_p0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pak_less(pak8),
    .out_valid(v_p0), .pak_more(d_p0)
  );
  pass_swap_stage #(.DIM(8), .PASS(1), .WIDTH(8)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pak_less(pak8),
    .out_valid(v_p1), .pak_more(d_p1)
  );
  pass_swap_stage #(.DIM(5), .PASS(0), .WIDTH(8)) u_d5a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pak_less(pak5),
    .out_valid(v_d5a), .pak_more(d_d5a)
  );
  pass_swap_stage #(.DIM(5), .PASS(1), .WIDTH(8)) u_d5b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pak_less(pak5),
    .out_valid(v_d5b), .pak_more(d_d5b)
  );

  for (genvar g = 0; g < 8; g++) begin : g_chain
    pass_swap_stage #(.DIM(8), .PASS(g), .WIDTH(8)) u_stage (
      .clk(clk), .rst(rst), .in_valid(c_v[g]), .pak_less(c_d[g]),
      .out_valid(c_v[g+1]), .pak_more(c_d[g+1])
    );
  end

  function automatic logic [63:0] mk8(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [39:0] mk5(input logic [7:0] e0, e1, e2, e3, e4);
    return {e4, e3, e2, e1, e0};
  endfunction

  // Reference: plain bubble sort ascending, element 0 smallest.
  function automatic logic [63:0] ref_sort(input logic [63:0] v);
    logic [7:0] e [8];
    logic [7:0] t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) e[i] = v[i*8 +: 8];
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 7 - i; k++) begin
        if (e[k] > e[k+1]) begin
          t = e[k]; e[k] = e[k+1]; e[k+1] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = e[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    pak8     = mk8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    pak5     = mk5(8'd9, 8'd8, 8'd7, 8'd6, 8'd5);
    c_v[0]   = 1'b1;
    c_d[0]   = 64'hFFEE_DDCC_BBAA_9988;
    tick();
    tick();
    n_total++;
    if (v_p0 !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid_p0 got=%b want=0", v_p0);
    end
    n_total++;
    if (d_p0 !== 64'h0) begin
      n_bad++; $display("FAIL reset_data_p0 got=%h want=0", d_p0);
    end
    n_total++;
    if (v_p1 !== 1'b0 || d_p1 !== 64'h0) begin
      n_bad++; $display("FAIL reset_p1 got=%b/%h want=0/0", v_p1, d_p1);
    end
    n_total++;
    if (v_d5a !== 1'b0 || d_d5a !== 40'h0) begin
      n_bad++; $display("FAIL reset_d5 got=%b/%h want=0/0", v_d5a, d_d5a);
    end
    n_total++;
    if (c_v[8] !== 1'b0 || c_d[8] !== 64'h0) begin
      n_bad++; $display("FAIL reset_chain got=%b/%h want=0/0", c_v[8], c_d[8]);
    end
    c_v[0] = 1'b0;
  endtask

  task automatic test_pass0();
    logic [63:0] exp;
    rst      = 1'b0;
    in_valid = 1'b1;
    pak8     = mk8(8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0);
    exp      = mk8(8'd6, 8'd7, 8'd4, 8'd5, 8'd2, 8'd3, 8'd0, 8'd1);
    tick();
    n_total++;
    if (v_p0 !== 1'b1) begin
      n_bad++; $display("FAIL pass0_valid got=%b want=1", v_p0);
    end
    n_total++;
    if (d_p0 !== exp) begin
      n_bad++; $display("FAIL pass0_data got=%h want=%h", d_p0, exp);
    end
  endtask

  task automatic test_pass1();
    logic [63:0] exp;
    in_valid = 1'b1;
    pak8     = mk8(8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0);
    exp      = mk8(8'd7, 8'd5, 8'd6, 8'd3, 8'd4, 8'd1, 8'd2, 8'd0);
    tick();
    n_total++;
    if (v_p1 !== 1'b1 || d_p1 !== exp) begin
      n_bad++; $display("FAIL pass1_data got=%b/%h want=1/%h", v_p1, d_p1, exp);
    end
  endtask

  task automatic test_ties_hold();
    logic [63:0] exp0, exp1;
    in_valid = 1'b1;
    pak8     = mk8(8'd3, 8'd3, 8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2);
    exp0     = mk8(8'd3, 8'd3, 8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2);
    exp1     = mk8(8'd3, 8'd3, 8'd3, 8'd1, 8'd3, 8'd1, 8'd2, 8'd2);
    tick();
    n_total++;
    if (v_p0 !== 1'b1 || d_p0 !== exp0) begin
      n_bad++; $display("FAIL ties_p0 got=%b/%h want=1/%h", v_p0, d_p0, exp0);
    end
    n_total++;
    if (d_p1 !== exp1) begin
      n_bad++; $display("FAIL ties_p1 got=%h want=%h", d_p1, exp1);
    end
    in_valid = 1'b0;
    pak8     = 64'h0102_0304_0506_0708;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (v_p0 !== 1'b0 || d_p0 !== exp0) begin
        n_bad++; $display("FAIL hold_%0d got=%b/%h want=0/%h", i, v_p0, d_p0, exp0);
      end
    end
  endtask

  task automatic test_dim5();
    logic [39:0] exp_a, exp_b;
    in_valid = 1'b1;
    pak5     = mk5(8'd9, 8'd8, 8'd7, 8'd6, 8'd5);
    exp_a    = mk5(8'd8, 8'd9, 8'd6, 8'd7, 8'd5);
    exp_b    = mk5(8'd9, 8'd7, 8'd8, 8'd5, 8'd6);
    tick();
    n_total++;
    if (v_d5a !== 1'b1 || d_d5a !== exp_a) begin
      n_bad++; $display("FAIL dim5_pass0 got=%b/%h want=1/%h", v_d5a, d_d5a, exp_a);
    end
    n_total++;
    if (v_d5b !== 1'b1 || d_d5b !== exp_b) begin
      n_bad++; $display("FAIL dim5_pass1 got=%b/%h want=1/%h", v_d5b, d_d5b, exp_b);
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1;
    pak8     = mk8(8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0);
    tick();
    rst  = 1'b1;
    pak8 = mk8(8'd9, 8'd1, 8'd9, 8'd1, 8'd9, 8'd1, 8'd9, 8'd1);
    tick();
    n_total++;
    if (v_p0 !== 1'b0 || d_p0 !== 64'h0) begin
      n_bad++; $display("FAIL midrst got=%b/%h want=0/0", v_p0, d_p0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    n_total++;
    if (v_p0 !== 1'b0 || d_p0 !== 64'h0) begin
      n_bad++; $display("FAIL midrst_after got=%b/%h want=0/0", v_p0, d_p0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] hist [100];
    logic [63:0] exp;
    logic        exp_v;
    int          idx;
    in_valid = 1'b0;
    for (int c = 0; c < 108; c++) begin
      if (c < 100) begin
        hist[c] = {$urandom(), $urandom()};
        c_v[0]  = 1'b1;
        c_d[0]  = hist[c];
      end else begin
        c_v[0] = 1'b0;
        c_d[0] = 64'h0;
      end
      tick();
      idx   = c - 7;
      exp_v = (idx >= 0) && (idx < 100);
      n_total++;
      if (c_v[8] !== exp_v) begin
        n_bad++; $display("FAIL chain_valid_c%0d got=%b want=%b", c, c_v[8], exp_v);
      end
      if (exp_v) begin
        exp = ref_sort(hist[idx]);
        n_total++;
        if (c_d[8] !== exp) begin
          n_bad++; $display("FAIL chain_sort_%0d got=%h want=%h", idx, c_d[8], exp);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    pak8     = 64'h0;
    pak5     = 40'h0;
    c_v[0]   = 1'b0;
    c_d[0]   = 64'h0;
    test_reset();
    test_pass0();
    test_pass1();
    test_ties_hold();
    test_dim5();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
